// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, state
// encoding and the token / data decode helpers.
package tmds_pkg;

    localparam int SYMBOL_W = 10;

    localparam logic [SYMBOL_W-1:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [SYMBOL_W-1:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [SYMBOL_W-1:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [SYMBOL_W-1:0] CTL_TOKEN_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctl;
    } token_t;

    function automatic token_t tmds_is_token(
        input logic [SYMBOL_W-1:0] sym
    );
        token_t r;
        r.hit = 1'b1;
        r.ctl = 2'b00;
        case (sym)
            CTL_TOKEN_00: r.ctl = 2'b00;
            CTL_TOKEN_01: r.ctl = 2'b01;
            CTL_TOKEN_10: r.ctl = 2'b10;
            CTL_TOKEN_11: r.ctl = 2'b11;
            default:      r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode_data(
        input logic [SYMBOL_W-1:0] sym
    );
        logic [7:0] t;
        logic [7:0] d;
        t    = sym[9] ? ~sym[7:0] : sym[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_aligner.sv
// Word aligner: bit-offset search over two adjacent symbols,
// locking on runs of control tokens and dropping lock on silence.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 16,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic                pixel_clk,
    input  logic                rst_n,
    input  logic [SYMBOL_W-1:0] sym_i,
    output logic [SYMBOL_W-1:0] win_o,
    output logic                locked_o,
    output logic [3:0]          offset_o,
    output logic [7:0]          realign_count_o
);

    localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int SRT_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int LST_W = $clog2(LOSS_TIMEOUT + 1);
    localparam int TMR_W = (SRT_W > LST_W) ? SRT_W : LST_W;

    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [TMR_W-1:0] SRCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST = TMR_W'(LOSS_TIMEOUT - 1);

    align_state_e        state_q, state_d;
    logic [SYMBOL_W-1:0] d1_q;
    logic [SYMBOL_W-1:0] win_q, win_d;
    logic [3:0]          offset_q, offset_d;
    logic [7:0]          rc_q, rc_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                holdoff_q, holdoff_d;
    logic [2*SYMBOL_W-1:0] cat;
    logic [4:0]          sel;
    token_t              tok;

    // Offset mux: pick 10 bits spanning the previous and current symbol
    always_comb begin
        cat   = {sym_i, d1_q};
        sel   = {1'b0, offset_q};
        win_d = cat[sel +: SYMBOL_W];
    end

    // Search / lock state machine, counters and offset stepping
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        rc_d      = rc_q;
        run_d     = run_q;
        timer_d   = timer_q;
        holdoff_d = 1'b0;
        tok       = tmds_is_token(win_q);
        unique case (state_q)
            SEARCH: begin
                if (!holdoff_q) begin
                    if (tok.hit) begin
                        timer_d = '0;
                        if (run_q == RUN_LAST) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                        if (timer_q == SRCH_LAST) begin
                            offset_d  = (offset_q == 4'd9) ? 4'd0
                                                           : offset_q + 4'd1;
                            rc_d      = (rc_q == 8'hFF) ? rc_q : rc_q + 8'd1;
                            timer_d   = '0;
                            holdoff_d = 1'b1;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
            end
            LOCKED: begin
                if (tok.hit) begin
                    timer_d = '0;
                end else if (timer_q == LOSS_LAST) begin
                    state_d = SEARCH;
                    run_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Pipeline and alignment state registers
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            d1_q      <= '0;
            win_q     <= '0;
            offset_q  <= '0;
            rc_q      <= '0;
            run_q     <= '0;
            timer_q   <= '0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d1_q      <= sym_i;
            win_q     <= win_d;
            offset_q  <= offset_d;
            rc_q      <= rc_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            holdoff_q <= holdoff_d;
        end
    end

    assign win_o           = win_q;
    assign locked_o        = (state_q == LOCKED);
    assign offset_o        = offset_q;
    assign realign_count_o = rc_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS (DVI) receive decoder: aligns the deserialized
// word stream and decodes control tokens and pixel bytes.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 16,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic                pixel_clk,
    input  logic                rst_n,
    input  logic [SYMBOL_W-1:0] sym_in,
    output logic                locked,
    output logic                de,
    output logic [1:0]          ctl,
    output logic [7:0]          data,
    output logic [3:0]          offset,
    output logic [7:0]          realign_count
);

    logic [SYMBOL_W-1:0] win;
    logic                lock_w;
    logic                de_q, de_d;
    logic [1:0]          ctl_q, ctl_d;
    logic [7:0]          data_q, data_d;
    token_t              tk;

    tmds_word_aligner #(
        .LOCK_TOKENS    (LOCK_TOKENS),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) u_aligner (
        .pixel_clk       (pixel_clk),
        .rst_n           (rst_n),
        .sym_i           (sym_in),
        .win_o           (win),
        .locked_o        (lock_w),
        .offset_o        (offset),
        .realign_count_o (realign_count)
    );

    // Decode the aligned window; silent while not locked
    always_comb begin
        de_d   = 1'b0;
        ctl_d  = ctl_q;
        data_d = 8'h00;
        tk     = tmds_is_token(win);
        if (!lock_w) begin
            ctl_d = 2'b00;
        end else if (tk.hit) begin
            ctl_d = tk.ctl;
        end else begin
            de_d   = 1'b1;
            data_d = tmds_decode_data(win);
        end
    end

    // Decoded output registers
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q   <= 1'b0;
            ctl_q  <= 2'b00;
            data_q <= 8'h00;
        end else begin
            de_q   <= de_d;
            ctl_q  <= ctl_d;
            data_q <= data_d;
        end
    end

    assign locked = lock_w;
    assign de     = de_q;
    assign ctl    = ctl_q;
    assign data   = data_q;

endmodule
